// File: rtl/int_to_raw_fn_pipe_pkg.sv
// Shared FPU definitions for the integer-to-raw-float path: rounding modes,
// the raw HardFloat result record and the exponent bias of the 64-bit normalizer.
package int_to_raw_fn_pipe_pkg;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;
    localparam logic [2:0] ODD = 3'd6;

    // sExp of a value whose leading one sits at bit 0 of the 64-bit magnitude
    localparam logic [8:0] RAW_EXP_BIAS_IN64 = 9'h080;

    typedef struct packed {
        logic        is_zero;
        logic        sign;
        logic [8:0]  s_exp;
        logic [64:0] sig;
    } raw_fn_t;

endpackage

// File: rtl/int_to_raw_fn_pipe_if.sv
// Operand/result handshake bundle for int_to_raw_fn_pipe.
// INT_TO_RAW_W32_EN adds the io_in_bits_is32 operand-width select.
interface int_to_raw_fn_pipe_if #(
    parameter int unsigned TAG_W = 5
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [63:0]      io_in_bits_int;
    logic             io_in_bits_signed;
    logic [2:0]       io_in_bits_rm;
    logic [TAG_W-1:0] io_in_bits_tag;
`ifdef INT_TO_RAW_W32_EN
    logic             io_in_bits_is32;
`endif
    logic             io_out_valid;
    logic             io_out_ready;
    logic             io_out_isZero;
    logic             io_out_sign;
    logic [8:0]       io_out_sExp;
    logic [64:0]      io_out_sig;
    logic [2:0]       io_out_rm;
    logic [TAG_W-1:0] io_out_tag;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output io_in_valid, io_in_bits_int, io_in_bits_signed, io_in_bits_rm, io_in_bits_tag,
`ifdef INT_TO_RAW_W32_EN
        output io_in_bits_is32,
`endif
        output io_out_ready,
        input  io_in_ready, io_out_valid, io_out_isZero, io_out_sign, io_out_sExp, io_out_sig,
        input  io_out_rm, io_out_tag
    );

    // Normalizer side
    modport slave (
        input  io_in_valid, io_in_bits_int, io_in_bits_signed, io_in_bits_rm, io_in_bits_tag,
`ifdef INT_TO_RAW_W32_EN
        input  io_in_bits_is32,
`endif
        input  io_out_ready,
        output io_in_ready, io_out_valid, io_out_isZero, io_out_sign, io_out_sExp, io_out_sig,
        output io_out_rm, io_out_tag
    );
endinterface

// File: rtl/int_to_raw_fn_pipe_lzc64.sv
// Combinational 64-bit leading-zero counter built as a binary tree.
// Each node carries an all-zero flag and the zero count within its span;
// a zero input yields 64.
module int_to_raw_fn_pipe_lzc64 (
    input  logic [63:0] value,
    output logic [6:0]  count
);
    logic [63:0]      z0;
    logic [31:0]      z1;
    logic [31:0]      c1;
    logic [15:0]      z2;
    logic [15:0][1:0] c2;
    logic [7:0]       z3;
    logic [7:0][2:0]  c3;
    logic [3:0]       z4;
    logic [3:0][3:0]  c4;
    logic [1:0]       z5;
    logic [1:0][4:0]  c5;
    logic             z6;
    logic [5:0]       c6;

    // Merge pairs level by level; node 0 is always the most-significant span
    always_comb begin
        for (int i = 0; i < 64; i++) z0[i] = ~value[63-i];
        for (int n = 0; n < 32; n++) begin
            z1[n] = z0[2*n] & z0[2*n+1];
            c1[n] = z0[2*n];
        end
        for (int n = 0; n < 16; n++) begin
            z2[n] = z1[2*n] & z1[2*n+1];
            c2[n] = z1[2*n] ? {1'b1, c1[2*n+1]} : {1'b0, c1[2*n]};
        end
        for (int n = 0; n < 8; n++) begin
            z3[n] = z2[2*n] & z2[2*n+1];
            c3[n] = z2[2*n] ? {1'b1, c2[2*n+1]} : {1'b0, c2[2*n]};
        end
        for (int n = 0; n < 4; n++) begin
            z4[n] = z3[2*n] & z3[2*n+1];
            c4[n] = z3[2*n] ? {1'b1, c3[2*n+1]} : {1'b0, c3[2*n]};
        end
        for (int n = 0; n < 2; n++) begin
            z5[n] = z4[2*n] & z4[2*n+1];
            c5[n] = z4[2*n] ? {1'b1, c4[2*n+1]} : {1'b0, c4[2*n]};
        end
        z6    = z5[0] & z5[1];
        c6    = z5[0] ? {1'b1, c5[1]} : {1'b0, c5[0]};
        count = z6 ? 7'd64 : {1'b0, c6};
    end

endmodule

// File: rtl/int_to_raw_fn_pipe.sv
// Two-stage integer-to-raw-float normalizer with valid/ready backpressure.
// Stage 1 takes the magnitude, stage 2 normalizes it via a leading-zero count.
// Optional: define INT_TO_RAW_W32_EN to accept 32-bit operands (io_in_bits_is32).
module int_to_raw_fn_pipe
    import int_to_raw_fn_pipe_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input logic                  clock,
    input logic                  reset,
    int_to_raw_fn_pipe_if.slave  io
);

    logic             s1_en;
    logic             s2_en;
    logic             s1_valid;
    logic             s1_sign;
    logic [63:0]      s1_abs;
    logic [2:0]       s1_rm;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    raw_fn_t          s2_raw;
    logic [2:0]       s2_rm;
    logic [TAG_W-1:0] s2_tag;

    logic [63:0]      in_op;
    logic             in_sign;
    logic [63:0]      in_abs;
    logic [6:0]       lz;
    raw_fn_t          norm;

    // A stage may load when empty or when the stage after it is draining
    assign s2_en       = !s2_valid | io.io_out_ready;
    assign s1_en       = !s1_valid | s2_en;
    assign io.io_in_ready = s1_en;

    // Operand widening and magnitude; the most negative value maps to 2^63
    always_comb begin
        in_op = io.io_in_bits_int;
`ifdef INT_TO_RAW_W32_EN
        if (io.io_in_bits_is32) begin
            in_op = io.io_in_bits_signed ?
                    {{32{io.io_in_bits_int[31]}}, io.io_in_bits_int[31:0]} :
                    {32'b0, io.io_in_bits_int[31:0]};
        end
`endif
        in_sign = io.io_in_bits_signed & in_op[63];
        in_abs  = in_sign ? (~in_op + 64'd1) : in_op;
    end

    int_to_raw_fn_pipe_lzc64 u_lzc (
        .value (s1_abs),
        .count (lz)
    );

    // Normalize so the leading one lands on sig[63]; a shift of 64 clears zero inputs
    always_comb begin
        norm.is_zero = (s1_abs == 64'd0);
        norm.sign    = s1_sign;
        norm.sig     = {1'b0, s1_abs << lz};
        norm.s_exp   = RAW_EXP_BIAS_IN64;
        if (!norm.is_zero) norm.s_exp = RAW_EXP_BIAS_IN64 + (9'd63 - {2'b0, lz});
    end

    // Stage 1 register: magnitude, sign and pass-through fields
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_abs   <= '0;
            s1_rm    <= '0;
            s1_tag   <= '0;
        end else if (s1_en) begin
            s1_valid <= io.io_in_valid;
            s1_sign  <= in_sign;
            s1_abs   <= in_abs;
            s1_rm    <= io.io_in_bits_rm;
            s1_tag   <= io.io_in_bits_tag;
        end
    end

    // Stage 2 register: normalized raw result, held while the consumer stalls
    always_ff @(posedge clock) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_raw   <= '0;
            s2_rm    <= '0;
            s2_tag   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            s2_raw   <= norm;
            s2_rm    <= s1_rm;
            s2_tag   <= s1_tag;
        end
    end

    assign io.io_out_valid  = s2_valid;
    assign io.io_out_isZero = s2_raw.is_zero;
    assign io.io_out_sign   = s2_raw.sign;
    assign io.io_out_sExp   = s2_raw.s_exp;
    assign io.io_out_sig    = s2_raw.sig;
    assign io.io_out_rm     = s2_rm;
    assign io.io_out_tag    = s2_tag;

endmodule

// File: tb/tb_int_to_raw_fn_pipe.sv
// Self-checking bench for int_to_raw_fn_pipe: directed vectors with literal
// expectations plus a scoreboard fed by a magnitude/MSB-search model.
// Covers INT_TO_RAW_W32_EN vectors when that macro is defined.
module tb_int_to_raw_fn_pipe;
    import int_to_raw_fn_pipe_pkg::*;

    localparam int unsigned TW = 5;

    typedef struct {
        raw_fn_t        r;
        logic [2:0]     rm;
        logic [TW-1:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic held = 1'b0;
    exp_t snap;

    logic [63:0] svec [8] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'h00F0_0000_0000_0000,
                              64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0001,
                              64'h0000_0001_0000_0000, 64'hDEAD_BEEF_0123_4567};

    int_to_raw_fn_pipe_if #(.TAG_W(TW)) io ();

    int_to_raw_fn_pipe #(.TAG_W(TW)) dut (
        .clock (clk),
        .reset (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: widen, take magnitude, find the top set bit, left-justify it
    function automatic raw_fn_t model(input logic [63:0] v, input logic sgn, input logic is32);
        logic [63:0] op;
        logic [63:0] mag;
        raw_fn_t     r;
        int          p;
        op = v;
        if (is32) op = sgn ? 64'($signed(v[31:0])) : 64'(v[31:0]);
        r.sign = sgn && op[63];
        mag = r.sign ? (64'd0 - op) : op;
        p = -1;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        if (p < 0) begin
            r.is_zero = 1'b1;
            r.s_exp   = 9'd128;
            r.sig     = '0;
        end else begin
            r.is_zero = 1'b0;
            r.s_exp   = 9'(128 + p);
            r.sig     = {1'b0, mag << (63 - p)};
        end
        return r;
    endfunction

    // Scoreboard: push on accept, compare on every delivered result, check stall holding
    always @(negedge clk) begin
        exp_t e;
        logic is32_now;
        if (!rst_n) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_sig", io.io_out_sig, snap.r.sig);
                chk("hold_sexp", 65'(io.io_out_sExp), 65'(snap.r.s_exp));
                chk("hold_tag", 65'(io.io_out_tag), 65'(snap.tag));
            end
            held = io.io_out_valid && !io.io_out_ready;
            snap.r.sig   = io.io_out_sig;
            snap.r.s_exp = io.io_out_sExp;
            snap.tag     = io.io_out_tag;
            if (io.io_out_valid && io.io_out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", io.io_out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_iszero", io.io_out_isZero, e.r.is_zero);
                    chk("sb_sign", io.io_out_sign, e.r.sign);
                    chk("sb_sexp", 65'(io.io_out_sExp), 65'(e.r.s_exp));
                    chk("sb_sig", io.io_out_sig, e.r.sig);
                    chk("sb_rm", 65'(io.io_out_rm), 65'(e.rm));
                    chk("sb_tag", 65'(io.io_out_tag), 65'(e.tag));
                end
            end
            if (io.io_in_valid && io.io_in_ready) begin
`ifdef INT_TO_RAW_W32_EN
                is32_now = io.io_in_bits_is32;
`else
                is32_now = 1'b0;
`endif
                e.r   = model(io.io_in_bits_int, io.io_in_bits_signed, is32_now);
                e.rm  = io.io_in_bits_rm;
                e.tag = io.io_in_bits_tag;
                sb.push_back(e);
            end
        end
    end

    // Present one operand and hold it until accepted (bounded)
    task automatic send(input logic [63:0] v, input logic sgn, input logic [2:0] rm,
                        input logic [TW-1:0] tag, input logic is32);
        logic acc;
        int   budget;
        io.io_in_valid       = 1'b1;
        io.io_in_bits_int    = v;
        io.io_in_bits_signed = sgn;
        io.io_in_bits_rm     = rm;
        io.io_in_bits_tag    = tag;
`ifdef INT_TO_RAW_W32_EN
        io.io_in_bits_is32   = is32;
`else
        if (is32) $display("note: is32 ignored without INT_TO_RAW_W32_EN");
`endif
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            @(negedge clk);
            acc = io.io_in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        io.io_in_valid = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    // Single operand through an idle pipe: 2-cycle latency, literal result
    task automatic send_check(input string name, input logic [63:0] v, input logic sgn,
                              input logic [2:0] rm, input logic [TW-1:0] tag, input logic is32,
                              input logic ez, input logic es, input logic [8:0] ee,
                              input logic [64:0] esig);
        send(v, sgn, rm, tag, is32);
        @(negedge clk);
        chk({name, "_lat1"}, io.io_out_valid, 1'b0);
        @(negedge clk);
        chk({name, "_lat2"}, io.io_out_valid, 1'b1);
        chk({name, "_iszero"}, io.io_out_isZero, ez);
        chk({name, "_sign"}, io.io_out_sign, es);
        chk({name, "_sexp"}, 65'(io.io_out_sExp), 65'(ee));
        chk({name, "_sig"}, io.io_out_sig, esig);
        chk({name, "_rm"}, 65'(io.io_out_rm), 65'(rm));
        chk({name, "_tag"}, 65'(io.io_out_tag), 65'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int   accepted;
        logic rdy;
        localparam logic [64:0] TOP = 65'h0_8000_0000_0000_0000;

        rst_n                = 1'b0;
        io.io_in_valid       = 1'b0;
        io.io_in_bits_int    = 64'h5555_AAAA_5555_AAAA;
        io.io_in_bits_signed = 1'b1;
        io.io_in_bits_rm     = RMM;
        io.io_in_bits_tag    = 5'd7;
`ifdef INT_TO_RAW_W32_EN
        io.io_in_bits_is32   = 1'b0;
`endif
        io.io_out_ready      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", io.io_out_valid, 1'b0);
        chk("rst_in_ready", io.io_in_ready, 1'b1);
        chk("rst_iszero", io.io_out_isZero, 1'b0);
        chk("rst_sexp", 65'(io.io_out_sExp), 65'd0);
        chk("rst_sig", io.io_out_sig, 65'd0);
        chk("rst_tag", 65'(io.io_out_tag), 65'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_check("one", 64'd1, 1'b1, RNE, 5'd1, 1'b0, 1'b0, 1'b0, 9'h080, TOP);
        send_check("neg1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, RUP, 5'd2, 1'b0, 1'b0, 1'b1, 9'h080, TOP);
        send_check("umax", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, RTZ, 5'd3, 1'b0,
                   1'b0, 1'b0, 9'h0BF, 65'h0_FFFF_FFFF_FFFF_FFFF);
        send_check("smin", 64'h8000_0000_0000_0000, 1'b1, RDN, 5'd4, 1'b0, 1'b0, 1'b1, 9'h0BF, TOP);
        send_check("zero", 64'd0, 1'b1, ODD, 5'd5, 1'b0, 1'b1, 1'b0, 9'h080, 65'd0);
        send_check("u16", 64'h10, 1'b0, RMM, 5'd6, 1'b0, 1'b0, 1'b0, 9'h084, TOP);
`ifdef INT_TO_RAW_W32_EN
        send_check("w32neg2", 64'h1234_5678_FFFF_FFFE, 1'b1, RNE, 5'd9, 1'b1,
                   1'b0, 1'b1, 9'h081, TOP);
        send_check("w32u1", 64'hFFFF_FFFF_0000_0001, 1'b0, RNE, 5'd10, 1'b1,
                   1'b0, 1'b0, 9'h080, TOP);
`endif

        // Permanent stall: only two operands fit, outputs hold
        io.io_out_ready      = 1'b0;
        io.io_in_valid       = 1'b1;
        io.io_in_bits_signed = 1'b0;
        io.io_in_bits_rm     = RNE;
        io.io_in_bits_tag    = 5'd1;
        io.io_in_bits_int    = 64'd100;
        accepted = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rdy = io.io_in_ready;
            chk("bp_in_ready", rdy, accepted < 2);
            if (c >= 2) begin
                chk("bp_out_valid", io.io_out_valid, 1'b1);
                chk("bp_out_tag", 65'(io.io_out_tag), 65'd1);
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted++;
                io.io_in_bits_tag = 5'(accepted + 1);
                io.io_in_bits_int = 64'(100 * (accepted + 1));
            end
        end
        io.io_out_ready = 1'b1;
        @(negedge clk);
        chk("drain_tag1", 65'(io.io_out_tag), 65'd1);
        chk("drain_valid1", io.io_out_valid, 1'b1);
        chk("drain_in_ready", io.io_in_ready, 1'b1);
        @(posedge clk);
        #1;
        io.io_in_valid = 1'b0;
        @(negedge clk);
        chk("drain_tag2", 65'(io.io_out_tag), 65'd2);
        chk("drain_valid2", io.io_out_valid, 1'b1);
        @(negedge clk);
        chk("drain_tag3", 65'(io.io_out_tag), 65'd3);
        chk("drain_valid3", io.io_out_valid, 1'b1);
        @(negedge clk);
        chk("drain_empty", io.io_out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back stream of 8 with no bubbles
        for (int i = 0; i < 11; i++) begin
            io.io_in_valid = (i < 8);
            if (i < 8) begin
                io.io_in_bits_int    = svec[i];
                io.io_in_bits_signed = 1'(i % 2);
                io.io_in_bits_rm     = 3'(i % 5);
                io.io_in_bits_tag    = 5'(i + 16);
            end
            @(negedge clk);
            chk("stream_valid", io.io_out_valid, (i >= 2) && (i < 10));
            if (i < 8) chk("stream_in_ready", io.io_in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        io.io_in_valid = 1'b0;

        // Reset with two operands in flight: nothing stale may emerge
        io.io_out_ready = 1'b0;
        send(64'd77, 1'b0, RNE, 5'd11, 1'b0);
        send(64'd88, 1'b0, RNE, 5'd12, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid", io.io_out_valid, 1'b0);
        chk("rstmid_in_ready", io.io_in_ready, 1'b1);
        io.io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_no_stale", io.io_out_valid, 1'b0);
        end
        chk("sb_drained", 65'(sb.size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
